cp0_unit: RTL

- Coprocessor-0 for the P7 pipelined MIPS core. Sits in the M stage, beside data memory.
- Holds SR, Cause, EPC and PRId.
- Executes mtc0 and eret, and evaluates hardware interrupts and M-stage exceptions.
- Drives IntReq/ExcReq, which flush the M/W pipeline register and redirect fetch to the handler, and CP0RD, which is latched into W for mfc0.

---
 rtl/cp0_pkg.sv | 29 ++
 rtl/cp0_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the P7 coprocessor-0: register numbers, exception
// codes and the bit positions of the SR/Cause fields.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int IM_LSB       = 10;
    localparam int EXL_BIT      = 1;
    localparam int IE_BIT       = 0;
    localparam int BD_BIT       = 31;
    localparam int IP_LSB       = 10;
    localparam int EXC_CODE_LSB = 2;
    localparam int EXC_CODE_W   = 5;

    // EPC always holds a word address.
    function automatic logic [31:0] word_align(input logic [31:0] w);
        return w & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0 of the P7 pipeline (M stage): SR/Cause/EPC/PRId storage,
// mtc0/eret execution and interrupt/exception request generation.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h2020_0701,
    parameter int          HW_INT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    input  logic [31:0]         pc_m,
    input  logic                bd_m,
    input  logic [4:0]          exc_code_m,
    input  logic                eret_m,
    input  logic [HW_INT_W-1:0] hw_int,
    output logic [31:0]         rdata,
    output logic [31:0]         epc,
    output logic                int_req,
    output logic                exc_req
);

    logic [HW_INT_W-1:0]   im_q, im_d;
    logic                  exl_q, exl_d;
    logic                  ie_q, ie_d;
    logic                  bd_q, bd_d;
    logic [HW_INT_W-1:0]   ip_q, ip_d;
    logic [EXC_CODE_W-1:0] exc_code_q, exc_code_d;
    logic [31:0]           epc_q, epc_d;

    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic [31:0] epc_target_s;
    logic        take_s;

    // Requests: interrupts win over exceptions, and nothing nests while EXL is set.
    always_comb begin
        int_req = ie_q & ~exl_q & (|(hw_int & im_q));
        exc_req = ~exl_q & (exc_code_m != 5'd0) & ~int_req;
        take_s  = int_req | exc_req;
    end

    // Restart address: a delay-slot instruction resumes at its branch.
    always_comb begin
        if (bd_m) begin
            epc_target_s = word_align(pc_m - 32'd4);
        end else begin
            epc_target_s = word_align(pc_m);
        end
    end

    // Register views assembled from the stored fields.
    always_comb begin
        sr_s                               = 32'd0;
        sr_s[IM_LSB +: HW_INT_W]           = im_q;
        sr_s[EXL_BIT]                      = exl_q;
        sr_s[IE_BIT]                       = ie_q;
        cause_s                            = 32'd0;
        cause_s[BD_BIT]                    = bd_q;
        cause_s[IP_LSB +: HW_INT_W]        = ip_q;
        cause_s[EXC_CODE_LSB +: EXC_CODE_W] = exc_code_q;
    end

    // mfc0 read mux; shows pre-write values during a same-cycle mtc0.
    always_comb begin
        case (addr)
            CP0_SR:    rdata = sr_s;
            CP0_CAUSE: rdata = cause_s;
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID;
            default:   rdata = 32'd0;
        endcase
        epc = epc_q;
    end

    // Next-state: reset, then request entry, then eret, then mtc0.
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (reset) begin
            im_d       = {HW_INT_W{1'b0}};
            exl_d      = 1'b0;
            ie_d       = 1'b0;
            bd_d       = 1'b0;
            ip_d       = {HW_INT_W{1'b0}};
            exc_code_d = 5'd0;
            epc_d      = 32'd0;
        end else if (take_s) begin
            exl_d      = 1'b1;
            exc_code_d = int_req ? EXC_INT : exc_code_m;
            bd_d       = bd_m;
            epc_d      = epc_target_s;
        end else begin
            if (eret_m) begin
                exl_d = 1'b0;
            end else begin
                exl_d = exl_q;
            end
            if (we) begin
                case (addr)
                    CP0_SR: begin
                        im_d  = wdata[IM_LSB +: HW_INT_W];
                        ie_d  = wdata[IE_BIT];
                        exl_d = eret_m ? 1'b0 : wdata[EXL_BIT];
                    end
                    CP0_EPC: epc_d = word_align(wdata);
                    default: epc_d = epc_q;
                endcase
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        im_q       <= im_d;
        exl_q      <= exl_d;
        ie_q       <= ie_d;
        bd_q       <= bd_d;
        ip_q       <= ip_d;
        exc_code_q <= exc_code_d;
        epc_q      <= epc_d;
    end

endmodule
